// File: rtl/pipe_pkg.sv
// Shared types for the pipeline register slice: state encoding and default payload width.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Occupancy is the state encoding itself; unknown encodings read as empty.
  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register with synchronous reset to RESET_VAL and a load enable.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Payload storage: reset has priority, otherwise load or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_reg_slice.sv
// Valid/ready pipeline register slice. Define PIPE_REG_SKID_EN for the two-entry skid
// variant with a registered in_ready; otherwise a single-entry slice is built.
module pipe_reg_slice
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic             out_valid_r;
  logic [1:0]       occ_r;
  logic             accept_s;
  logic             consume_s;
  logic             load_out_s;
  logic [WIDTH-1:0] out_d_s;

`ifdef PIPE_REG_SKID_EN
  logic             in_ready_r;
  logic             load_skid_s;
  logic [WIDTH-1:0] skid_q_s;

  assign in_ready = in_ready_r;
`else
  assign in_ready = !out_valid_r || out_ready;
`endif

  assign out_valid = out_valid_r;
  assign occupancy = occ_r;

  // Handshakes and data-register load enables; flush blocks every load so held data is kept.
  always_comb begin
    accept_s   = in_valid && in_ready && !flush;
    consume_s  = out_valid_r && out_ready && !flush;
    load_out_s = 1'b0;
    out_d_s    = in_data;
`ifdef PIPE_REG_SKID_EN
    load_skid_s = 1'b0;
`endif
    case (state_r)
      EMPTY: begin
        load_out_s = accept_s;
      end
      ONE: begin
        load_out_s = accept_s && consume_s;
`ifdef PIPE_REG_SKID_EN
        load_skid_s = accept_s && !consume_s;
`endif
      end
      TWO: begin
`ifdef PIPE_REG_SKID_EN
        load_out_s = consume_s;
        out_d_s    = skid_q_s;
`else
        load_out_s = 1'b0;
`endif
      end
      default: begin
        load_out_s = 1'b0;
      end
    endcase
  end

  // Next-state selection; flush overrides any transfer in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
`ifdef PIPE_REG_SKID_EN
          if (accept_s && !consume_s) begin
            state_nxt_s = TWO;
          end else if (consume_s && !accept_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
`else
          if (consume_s && !accept_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
`endif
        end
        TWO: begin
`ifdef PIPE_REG_SKID_EN
          if (consume_s) begin
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = TWO;
          end
`else
          state_nxt_s = EMPTY;
`endif
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // State register with all control outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      occ_r       <= 2'd0;
`ifdef PIPE_REG_SKID_EN
      in_ready_r  <= 1'b1;
`endif
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s != EMPTY);
      occ_r       <= occ_of(state_nxt_s);
`ifdef PIPE_REG_SKID_EN
      in_ready_r  <= (state_nxt_s != TWO);
`endif
    end
  end

  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_out_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load_out_s),
    .d    (out_d_s),
    .q    (out_data)
  );

`ifdef PIPE_REG_SKID_EN
  // Skid entry only ever captures upstream data when the head register is occupied.
  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load_skid_s),
    .d    (in_data),
    .q    (skid_q_s)
  );
`endif

endmodule

// File: tb/tb_pipe_reg_slice.sv
// Self-checking bench for pipe_reg_slice: directed scenarios plus random traffic compared
// against a FIFO-queue reference model (capacity 2 with PIPE_REG_SKID_EN, else 1).
module tb_pipe_reg_slice;

  localparam int W = 32;
`ifdef PIPE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic [1:0]   occupancy;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] last_out = '0;
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;

  always #5 clk = ~clk;

  pipe_reg_slice #(.WIDTH(W), .RESET_VAL(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Upstream may transfer whenever the queue has room, or (single entry) when the head leaves.
  function automatic bit model_ready(input bit r);
    if (SKID) return q.size() < 2;
    else return (q.size() == 0) || r;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                      input logic fl, input logic rs, input bit do_chk);
    bit acc;
    bit cons;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = fl;
    rst       = rs;
    #1;
    acc  = v && model_ready(r);
    cons = (q.size() > 0) && r;
    if (do_chk) begin
      chk_eq("in_ready", in_ready, model_ready(r));
      chk_eq("out_valid", out_valid, q.size() > 0);
      chk_eq("occupancy", occupancy, q.size());
      chk_eq("out_data", out_data, (q.size() > 0) ? q[0] : last_out);
      if (prev_hold) chk_eq("hold_stable", out_data, prev_data);
    end
    prev_hold = (q.size() > 0) && !r && !fl && !rs;
    prev_data = out_data;
    @(posedge clk);
    if (rs) begin
      q.delete();
      last_out = '0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    if (q.size() > 0) last_out = q[0];
  endtask

  initial begin
    // Two reset cycles, then first cycle after release
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back stream with continuous out_ready
    step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1);

`ifdef PIPE_REG_SKID_EN
    // Fill the skid entry under backpressure, then drain
    step(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1);
    // Full slice flushed with a simultaneous offer of 0xFF
    step(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1);
`else
    // Held entry flushed with a simultaneous offer of 0xFF
    step(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1);
`endif

    // Reset together with flush while 0x55 is held
    step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hAB, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 255) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
